serial_subtractor: RTL and testbench

- Digit-serial N-bit subtractor computing D = A - B - Bin, processing DIGIT bits per clock, LSB digit first.
- Inverse-direction companion to the team's combinational ripple-carry adder; shares its operand width and carry/borrow conventions.
- Sits behind a valid/ready operand interface and in front of a valid/ready result interface, for area-constrained datapaths.

---
 rtl/serial_sub_pkg.sv | 23 ++
 rtl/digit_subtractor.sv | 29 ++
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Optional add mode in serial_subtractor is enabled by SERIAL_SUB_ADDMODE_EN.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of DIGIT-wide slices in an N-bit operand.
   function automatic int num_digits(input int n, input int digit);
      return n / digit;
   endfunction

   // Width of the digit counter; never narrower than one bit.
   function automatic int cnt_width(input int n, input int digit);
      int w;
      w = $clog2(n / digit);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit borrow-ripple subtractor: {bo, diff} = x - y - bi.
module digit_subtractor
   import serial_sub_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             bi,
   output logic [DIGIT-1:0] diff,
   output logic             bo
);

   logic [DIGIT:0] br;

   // Ripple the borrow from bit 0 upwards, one full subtractor per bit.
   always_comb begin
      br    = '0;
      diff  = '0;
      br[0] = bi;
      for (int i = 0; i < DIGIT; i++) begin
         diff[i]  = x[i] ^ y[i] ^ br[i];
         br[i+1]  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
      end
   end

   assign bo = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial N-bit subtractor, D = A - B - Bin, LSB digit first.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid is never withdrawn by this block once raised, and the
// result (d, bout, ovf) stays stable while out_valid && !out_ready.
// Defining SERIAL_SUB_ADDMODE_EN adds an op input (1 = add) that reuses the
// subtract datapath with b inverted and the borrow/carry sense flipped.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int N     = 16,
   parameter int DIGIT = 4
) (
   input  logic         clk,
   input  logic         rst,
`ifdef SERIAL_SUB_ADDMODE_EN
   input  logic         op,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] d,
   output logic         bout,
   output logic         ovf
);

   localparam int ND = num_digits(N, DIGIT);
   localparam int CW = cnt_width(N, DIGIT);
   localparam logic [CW-1:0] LAST = CW'(ND - 1);

   generate
      if (N % DIGIT != 0) begin : g_bad_digit
         $error("serial_subtractor: N must be a multiple of DIGIT");
      end
   endgenerate

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [N-1:0]    a_q;
   logic [N-1:0]    b_q;
   logic            borrow;
   logic            a_msb;
   logic            b_msb;
   logic            op_q;
   logic [DIGIT-1:0] diff;
   logic            bo;
   logic [N+DIGIT-1:0] d_cat;

   digit_subtractor #(.DIGIT(DIGIT)) u_digit (
      .x    (a_q[DIGIT-1:0]),
      .y    (b_q[DIGIT-1:0]),
      .bi   (borrow),
      .diff (diff),
      .bo   (bo)
   );

   // New digit enters at the top of d; after ND shifts the result is aligned.
   assign d_cat = {diff, d};

   // Control FSM, operand shifters, result shift register and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         d         <= '0;
         bout      <= 1'b0;
         ovf       <= 1'b0;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         borrow    <= 1'b0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         op_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
`ifdef SERIAL_SUB_ADDMODE_EN
                  // Add is a - ~b with inverted carry-in/carry-out.
                  op_q   <= op;
                  a_q    <= a;
                  b_q    <= op ? ~b : b;
                  borrow <= op ? ~bin : bin;
                  a_msb  <= a[N-1];
                  b_msb  <= op ? ~b[N-1] : b[N-1];
`else
                  op_q   <= 1'b0;
                  a_q    <= a;
                  b_q    <= b;
                  borrow <= bin;
                  a_msb  <= a[N-1];
                  b_msb  <= b[N-1];
`endif
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               d      <= d_cat[N+DIGIT-1:DIGIT];
               a_q    <= a_q >> DIGIT;
               b_q    <= b_q >> DIGIT;
               borrow <= bo;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  bout      <= op_q ? ~bo : bo;
                  // b_msb is the effective subtrahend sign, so one formula
                  // covers both subtract and add.
                  ovf       <= (a_msb != b_msb) && (diff[DIGIT-1] != a_msb);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (N=16, DIGIT=4).
module tb_serial_subtractor;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         op_r;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] d;
   logic         bout;
   logic         ovf;

   int vectors    = 0;
   int miscompares = 0;

   logic [N:0] exp_q[$];

   serial_subtractor #(.N(16), .DIGIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef SERIAL_SUB_ADDMODE_EN
      .op        (op_r),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .ovf       (ovf)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full operation: accept, wait for result, check latency/result, drain.
   task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic bi, input logic [N-1:0] ed, input logic eb,
                         input logic eo);
      int lat;
      logic rdy_seen;
      a = av; b = bv; bin = bi; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 20) begin
         if (in_ready) rdy_seen = 1'b1;
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, 4);
      chk({tag, "_rdy_low"}, rdy_seen, 0);
      chk({tag, "_d"}, d, ed);
      chk({tag, "_bout"}, bout, eb);
      chk({tag, "_ovf"}, ovf, eo);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_ov_drop"}, out_valid, 0);
      chk({tag, "_ir_back"}, in_ready, 1);
   endtask

   initial begin
      int cyc, last_acc, nacc, nres;
      logic acc_now;
      logic [N:0] exp_v;
      logic [N-1:0] ba [3];
      logic [N-1:0] bb [3];
      logic         bc [3];

      rst = 1'b1; op_r = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_d", d, 0);
      chk("rst_bout", bout, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b0;
      tick();

      run_op("basic", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
      run_op("uflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      run_op("sovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);

      // Borrow-in with backpressure while new operands are offered.
      a = 16'h0005; b = 16'h0005; bin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("bp_ov", out_valid, 1);
      chk("bp_d", d, 16'hFFFF);
      chk("bp_bout", bout, 1);
      a = 16'hAAAA; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_d", d, 16'hFFFF);
         chk("bp_hold_bout", bout, 1);
         chk("bp_hold_ov", out_valid, 1);
         chk("bp_hold_ir", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_ir_back", in_ready, 1);
      chk("bp_ov_drop", out_valid, 0);
      chk("bp_idle_d", d, 16'hFFFF);
      tick();
      chk("bp_not_taken", in_ready, 1);

      // Reset after two digits have been processed.
      a = 16'h1234; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_ir", in_ready, 1);
      chk("mid_rst_d", d, 0);
      chk("mid_rst_bout", bout, 0);
      run_op("post_rst", 16'h0100, 16'h00FF, 1'b0, 16'h0001, 1'b0, 1'b0);

      // Reset and in_valid together: operands must not be captured.
      a = 16'h4444; b = 16'h1111; in_valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      tick();
      chk("rst_vs_valid_ir", in_ready, 1);
      chk("rst_vs_valid_d", d, 0);

      // Back-to-back with in_valid and out_ready held high.
      ba[0] = 16'h0010; bb[0] = 16'h0001; bc[0] = 1'b0;
      ba[1] = 16'h1000; bb[1] = 16'h2000; bc[1] = 1'b0;
      ba[2] = 16'hFFFF; bb[2] = 16'hFFFF; bc[2] = 1'b1;
      exp_q.delete();
      cyc = 0; last_acc = 0; nacc = 0; nres = 0;
      a = ba[0]; b = bb[0]; bin = bc[0];
      in_valid = 1'b1; out_ready = 1'b1;
      while (nres < 3 && cyc < 60) begin
         acc_now = in_ready && in_valid;
         tick();
         cyc++;
         if (acc_now) begin
            case (nacc)
               0: exp_q.push_back({1'b0, 16'h000F});
               1: exp_q.push_back({1'b1, 16'hF000});
               default: exp_q.push_back({1'b1, 16'hFFFF});
            endcase
            if (nacc > 0) chk("b2b_spacing", cyc - last_acc, 6);
            last_acc = cyc;
            nacc++;
            if (nacc < 3) begin
               a = ba[nacc]; b = bb[nacc]; bin = bc[nacc];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            if (exp_q.size() > 0) begin
               exp_v = exp_q.pop_front();
               chk("b2b_result", {bout, d}, exp_v);
            end else begin
               chk("b2b_unexpected", 1, 0);
            end
            nres++;
         end
      end
      chk("b2b_count", nres, 3);
      in_valid = 1'b0; out_ready = 1'b0;
      tick();

`ifdef SERIAL_SUB_ADDMODE_EN
      op_r = 1'b1;
      run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      op_r = 1'b0;
      run_op("sub_after_add", 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
